// File: rtl/div32_seq.sv
// Radix-2 restoring divider for DIV/DIVU: quotient and remainder in WIDTH+1 clocks from start.
// Start is ignored while busy; q/r hold until the next accepted divide completes.
module div32_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             ready,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic             sa;
  logic             sb;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             ge;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  // A set top bit of the shifted remainder already exceeds any WIDTH-bit divisor,
  // so only the low WIDTH bits go through the subtractor.
  assign rem_sh          = {rem, quo[WIDTH-1]};
  assign {borrow, diff}  = {1'b0, rem_sh[WIDTH-1:0]} - {1'b0, dvs};
  assign ge              = rem_sh[WIDTH] | ~borrow;

  // Divide by zero leaves rem = |dividend|, so the dividend-sign fix restores the raw dividend.
  assign q_fix = (dvs == '0) ? '1 : ((sa ^ sb) ? -quo : quo);
  assign r_fix = sa ? -rem : rem;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state <= IDLE;
      count <= '0;
      rem   <= '0;
      quo   <= '0;
      dvs   <= '0;
      sa    <= 1'b0;
      sb    <= 1'b0;
      busy  <= 1'b0;
      ready <= 1'b0;
      q     <= '0;
      r     <= '0;
    end else begin
      ready <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sa    <= is_signed & dividend[WIDTH-1];
            sb    <= is_signed & divisor[WIDTH-1];
            quo   <= (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
            dvs   <= (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
            rem   <= '0;
            count <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          rem   <= ge ? diff : rem_sh[WIDTH-1:0];
          quo   <= {quo[WIDTH-2:0], ge};
          count <= count + 1'b1;
          if (count == CW'(WIDTH - 1)) state <= DONE;
        end
        DONE: begin
          q     <= q_fix;
          r     <= r_fix;
          ready <= 1'b1;
          busy  <= 1'b0;
          count <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div32_seq.sv
// Bench for div32_seq: directed vector table, multi-cycle corner sequences,
// and randomized signed/unsigned divides against an arithmetic reference.
module tb_div32_seq;

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy;
  logic        ready;
  logic [31:0] q;
  logic [31:0] r;

  int nvec = 0;
  int nerr = 0;

  div32_seq #(.WIDTH(32)) dut (
    .clk(clk), .clrn(clrn), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .ready(ready), .q(q), .r(r)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Truncating division from plain arithmetic; divide-by-zero rule applied first.
  function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [31:0] rq, rr;
    if (b == 32'd0) begin
      rq = 32'hFFFF_FFFF;
      rr = a;
    end else if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      rq = 32'(sa / sb);
      rr = 32'(sa % sb);
    end else begin
      rq = a / b;
      rr = a % b;
    end
    return {rq, rr};
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0: v = 32'd0;
      1: v = 32'd1;
      2: v = 32'hFFFF_FFFF;
      3: v = 32'h8000_0000;
      4: v = 32'h7FFF_FFFF;
      5: v = 32'($urandom_range(0, 15));
      6: v = -32'($urandom_range(1, 15));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Ends at the negedge after the accepting edge; operands are then scrambled.
  task automatic issue(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    is_signed = sgn;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start     = 1'b0;
    dividend  = $urandom;
    divisor   = $urandom;
    is_signed = 1'($urandom);
  endtask

  // n = edges after the accepting edge until ready is seen; bc = busy samples before that.
  task automatic wait_ready(output int n, output int bc);
    n  = 0;
    bc = busy ? 1 : 0;
    while (n < 100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (ready) break;
      if (busy) bc++;
    end
  endtask

  task automatic run_op(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er, input bit full);
    int n, bc;
    issue(sgn, a, b);
    wait_ready(n, bc);
    chk("latency", 32'(n), 32'd33);
    chk("q", q, eq);
    chk("r", r, er);
    if (full) begin
      chk("busy_cycles", 32'(bc), 32'd33);
      chk("busy_at_ready", {31'd0, busy}, 32'd0);
    end
  endtask

  initial begin
    int n, bc;
    int seen;
    logic [63:0] exp;
    bit sgn;
    logic [31:0] a, b;

    tbl[0] = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2};
    tbl[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF};
    tbl[2] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1};
    tbl[3] = '{1'b0, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678};
    tbl[4] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0};
    tbl[5] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000};
    tbl[6] = '{1'b1, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFF9};
    tbl[7] = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'd1,          32'd1};
    tbl[8] = '{1'b1, 32'h8000_0000,  32'd2,          32'hC000_0000,  32'd0};
    tbl[9] = '{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF};

    // Reset state
    #12;
    chk("rst_busy",  {31'd0, busy},  32'd0);
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_q", q, 32'd0);
    chk("rst_r", r, 32'd0);
    @(negedge clk);
    clrn = 1'b1;

    // Directed table
    for (int i = 0; i < 10; i++)
      run_op(tbl[i].sgn, tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, 1'b1);

    // Start while busy is ignored; then start on the ready cycle is accepted
    issue(1'b0, 32'd50, 32'd5);
    repeat (9) @(negedge clk);
    is_signed = 1'b0;
    dividend  = 32'd9;
    divisor   = 32'd4;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_ready(n, bc);
    chk("busy_start_latency", 32'(n + 10), 32'd33);
    chk("busy_start_q", q, 32'd10);
    chk("busy_start_r", r, 32'd0);
    is_signed = 1'b0;
    dividend  = 32'd9;
    divisor   = 32'd4;
    start     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    chk("b2b_ready_drop", {31'd0, ready}, 32'd0);
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    chk("b2b_q_held", q, 32'd10);
    wait_ready(n, bc);
    chk("b2b_latency", 32'(n), 32'd33);
    chk("b2b_q", q, 32'd2);
    chk("b2b_r", r, 32'd1);

    // Reset mid-run abandons the divide
    issue(1'b0, 32'd1000, 32'd3);
    repeat (14) @(negedge clk);
    clrn = 1'b0;
    #1;
    chk("midrst_busy",  {31'd0, busy},  32'd0);
    chk("midrst_ready", {31'd0, ready}, 32'd0);
    chk("midrst_q", q, 32'd0);
    chk("midrst_r", r, 32'd0);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ready) seen++;
    end
    chk("midrst_no_ready", 32'(seen), 32'd0);
    clrn = 1'b1;
    run_op(1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 1'b1);

    // Randomized against the reference
    for (int i = 0; i < 1200; i++) begin
      sgn = 1'($urandom);
      a   = pick();
      b   = pick();
      exp = ref_div(sgn, a, b);
      run_op(sgn, a, b, exp[63:32], exp[31:0], 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
